// File: rtl/vga_if.sv
// vga_if: one pixel of VGA timing plus its 12-bit colour.
//   vcount/hcount : 11-bit scan position
//   vsync/hsync   : sync pulses
//   vblnk/hblnk   : blanking flags
//   rgb           : 12-bit colour (4:4:4)
// master drives the stream, slave receives it.
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport master (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport slave  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/menu_select.sv
// menu_select: menu navigation FSM with a highlight-frame overlay on a VGA stream.
//   clk         : pixel clock
//   rst         : asynchronous reset, active low
//   vga_in      : timing + rgb from the menu background stage
//   vga_out     : same stream delayed 1 clk, highlight frame painted in
//   menu_active : menu is shown and navigable
//   btn_up/btn_down/btn_enter : single-cycle button pulses
//   sel_idx     : committed selection
//   sel_valid   : one-cycle pulse when a selection is confirmed
//
// state   | meaning
// BROWSE  | up/down move cur_idx, enter starts confirmation
// CONFIRM | highlight blinks, frames counted up to CONFIRM_FRAMES
// DONE    | selection committed, buttons ignored
module menu_select #(
    parameter int          N_OPTIONS      = 3,
    parameter int          BOX_X          = 256,
    parameter int          BOX_Y0         = 200,
    parameter int          BOX_W          = 512,
    parameter int          BOX_H          = 64,
    parameter int          BOX_PITCH      = 96,
    parameter int          BORDER         = 4,
    parameter logic [11:0] HL_COLOR       = 12'hFFF,
    parameter int          CONFIRM_FRAMES = 32
) (
    input  logic       clk,
    input  logic       rst,
    vga_if.slave       vga_in,
    vga_if.master      vga_out,
    input  logic       menu_active,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_enter,
    output logic [1:0] sel_idx,
    output logic       sel_valid
);

    // Counter needs bit 2 for the blink even if CONFIRM_FRAMES is small.
    localparam int FW = ($clog2(CONFIRM_FRAMES + 1) < 3) ? 3 : $clog2(CONFIRM_FRAMES + 1);
    localparam logic [FW-1:0] FCNT_END = FW'(CONFIRM_FRAMES);
    localparam logic [1:0]    LAST_IDX = 2'(N_OPTIONS - 1);

    localparam logic [10:0] X_LO  = 11'(BOX_X);
    localparam logic [10:0] X_HI  = 11'(BOX_X + BOX_W);
    localparam logic [10:0] XI_LO = 11'(BOX_X + BORDER);
    localparam logic [10:0] XI_HI = 11'(BOX_X + BOX_W - BORDER);

    typedef enum logic [1:0] {BROWSE, CONFIRM, DONE} state_t;

    state_t        state;
    logic [1:0]    cur_idx;
    logic [1:0]    disp_idx;
    logic          disp_ok;
    logic [FW-1:0] fcnt;
    logic [FW-1:0] fcnt_inc;

    logic          frame_start;
    logic [10:0]   box_top, box_bot, in_top, in_bot;
    logic          in_outer, in_inner, idx_ok, hl_vis, hl_pix;

    assign frame_start = (vga_in.vcount == 11'd0) && (vga_in.hcount == 11'd0);
    assign fcnt_inc    = fcnt + FW'(1);

    always_comb begin
        box_top  = 11'(BOX_Y0) + 11'(disp_idx) * 11'(BOX_PITCH);
        box_bot  = box_top + 11'(BOX_H);
        in_top   = box_top + 11'(BORDER);
        in_bot   = box_bot - 11'(BORDER);
        in_outer = (vga_in.hcount >= X_LO) && (vga_in.hcount < X_HI) &&
                   (vga_in.vcount >= box_top) && (vga_in.vcount < box_bot);
        in_inner = (vga_in.hcount >= XI_LO) && (vga_in.hcount < XI_HI) &&
                   (vga_in.vcount >= in_top) && (vga_in.vcount < in_bot);
        idx_ok   = ({1'b0, disp_idx} < 3'(N_OPTIONS));
        hl_vis   = (state == BROWSE) || (state == DONE) ||
                   ((state == CONFIRM) && !fcnt[2]);
        hl_pix   = menu_active && disp_ok && !vga_in.hblnk && !vga_in.vblnk &&
                   hl_vis && idx_ok && in_outer && !in_inner;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vga_out.vcount <= '0;
            vga_out.vsync  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.hcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.rgb    <= '0;
        end else begin
            vga_out.vcount <= vga_in.vcount;
            vga_out.vsync  <= vga_in.vsync;
            vga_out.vblnk  <= vga_in.vblnk;
            vga_out.hcount <= vga_in.hcount;
            vga_out.hsync  <= vga_in.hsync;
            vga_out.hblnk  <= vga_in.hblnk;
            vga_out.rgb    <= hl_pix ? HL_COLOR : vga_in.rgb;
        end
    end

    // disp_idx only follows cur_idx at frame boundaries so the box never
    // jumps mid-frame; disp_ok keeps the overlay off until the first boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_idx <= 2'd0;
            disp_ok  <= 1'b0;
        end else if (frame_start) begin
            disp_idx <= cur_idx;
            disp_ok  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= BROWSE;
            cur_idx   <= 2'd0;
            sel_idx   <= 2'd0;
            sel_valid <= 1'b0;
            fcnt      <= '0;
        end else begin
            sel_valid <= 1'b0;
            if (!menu_active) begin
                state <= BROWSE;
                fcnt  <= '0;
            end else begin
                case (state)
                    BROWSE: begin
                        if (btn_enter) begin
                            state <= CONFIRM;
                            fcnt  <= '0;
                        end else if (btn_up && !btn_down) begin
                            cur_idx <= (cur_idx == 2'd0) ? LAST_IDX : cur_idx - 2'd1;
                        end else if (btn_down && !btn_up) begin
                            cur_idx <= (cur_idx == LAST_IDX) ? 2'd0 : cur_idx + 2'd1;
                        end
                    end
                    CONFIRM: begin
                        if (frame_start) begin
                            fcnt <= fcnt_inc;
                            if (fcnt_inc == FCNT_END) begin
                                state     <= DONE;
                                sel_idx   <= cur_idx;
                                sel_valid <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                    end
                    default: state <= BROWSE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_menu_select.sv
module tb_menu_select;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       menu_active = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_enter = 1'b0;
    logic [1:0] sel_idx;
    logic       sel_valid;

    int tests  = 0;
    int failed = 0;
    int sv_cnt = 0;

    vga_if vin ();
    vga_if vout ();

    menu_select dut (
        .clk         (clk),
        .rst         (rst),
        .vga_in      (vin),
        .vga_out     (vout),
        .menu_active (menu_active),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_enter   (btn_enter),
        .sel_idx     (sel_idx),
        .sel_valid   (sel_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] h;
        logic [10:0] v;
        logic        hb;
        logic        vb;
        logic [11:0] exp_rgb;
    } vec_t;

    localparam logic [11:0] BG = 12'h0A5;
    localparam logic [11:0] HL = 12'hFFF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [10:0] h, input logic [10:0] v, input logic hb,
                        input logic vb, input logic [11:0] rgb,
                        input logic u, input logic d, input logic e);
        @(negedge clk);
        vin.hcount = h;
        vin.vcount = v;
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.hsync  = h[0];
        vin.vsync  = v[1];
        vin.rgb    = rgb;
        btn_up     = u;
        btn_down   = d;
        btn_enter  = e;
        @(posedge clk);
        #1;
        if (sel_valid) sv_cnt++;
    endtask

    task automatic pix(input logic [10:0] h, input logic [10:0] v);
        step(h, v, 1'b0, 1'b0, BG, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame();
        step(11'd0, 11'd0, 1'b0, 1'b0, BG, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic btn(input logic u, input logic d, input logic e);
        step(11'd600, 11'd500, 1'b0, 1'b0, BG, u, d, e);
    endtask

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{11'd256, 11'd200, 1'b0, 1'b0, HL};
        vecs[1]  = '{11'd259, 11'd230, 1'b0, 1'b0, HL};
        vecs[2]  = '{11'd260, 11'd230, 1'b0, 1'b0, BG};
        vecs[3]  = '{11'd767, 11'd263, 1'b0, 1'b0, HL};
        vecs[4]  = '{11'd768, 11'd230, 1'b0, 1'b0, BG};
        vecs[5]  = '{11'd255, 11'd230, 1'b0, 1'b0, BG};
        vecs[6]  = '{11'd400, 11'd199, 1'b0, 1'b0, BG};
        vecs[7]  = '{11'd400, 11'd264, 1'b0, 1'b0, BG};
        vecs[8]  = '{11'd400, 11'd203, 1'b0, 1'b0, HL};
        vecs[9]  = '{11'd400, 11'd204, 1'b0, 1'b0, BG};
        vecs[10] = '{11'd400, 11'd260, 1'b0, 1'b0, HL};
        vecs[11] = '{11'd256, 11'd200, 1'b1, 1'b0, BG};
        vecs[12] = '{11'd256, 11'd200, 1'b0, 1'b1, BG};
        vecs[13] = '{11'd256, 11'd296, 1'b0, 1'b0, BG};

        vin.hcount = 11'd256; vin.vcount = 11'd200; vin.hblnk = 1'b0; vin.vblnk = 1'b0;
        vin.hsync = 1'b1; vin.vsync = 1'b1; vin.rgb = BG;

        // reset state
        #12;
        chk("rst_rgb", 32'(vout.rgb), 32'h0);
        chk("rst_hcount", 32'(vout.hcount), 32'h0);
        chk("rst_sel_idx", 32'(sel_idx), 32'h0);
        chk("rst_sel_valid", 32'(sel_valid), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        menu_active = 1'b1;

        // no highlight before the first frame_start
        pix(11'd256, 11'd200);
        chk("pre_frame_no_hl", 32'(vout.rgb), 32'(BG));
        frame();

        // idle stream, box 0 border ring
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].h, vecs[i].v, vecs[i].hb, vecs[i].vb, BG, 1'b0, 1'b0, 1'b0);
            chk($sformatf("vec%0d_rgb", i), 32'(vout.rgb), 32'(vecs[i].exp_rgb));
            chk($sformatf("vec%0d_timing", i),
                {vout.hcount, vout.vcount, vout.hblnk, vout.vblnk, vout.hsync, vout.vsync},
                {vecs[i].h, vecs[i].v, vecs[i].hb, vecs[i].vb, vecs[i].h[0], vecs[i].v[1]});
        end

        // up from 0 wraps to 2; highlight waits for frame_start
        btn(1'b1, 1'b0, 1'b0);
        pix(11'd256, 11'd392);
        chk("up_wrap_box2_before_frame", 32'(vout.rgb), 32'(BG));
        pix(11'd256, 11'd200);
        chk("up_wrap_box0_still", 32'(vout.rgb), 32'(HL));
        frame();
        pix(11'd256, 11'd392);
        chk("up_wrap_box2_top", 32'(vout.rgb), 32'(HL));
        pix(11'd767, 11'd455);
        chk("up_wrap_box2_bot", 32'(vout.rgb), 32'(HL));
        pix(11'd256, 11'd200);
        chk("up_wrap_box0_off", 32'(vout.rgb), 32'(BG));

        // down wraps 2 -> 0 -> 1
        btn(1'b0, 1'b1, 1'b0);
        btn(1'b0, 1'b1, 1'b0);
        frame();
        pix(11'd256, 11'd296);
        chk("down_to_box1", 32'(vout.rgb), 32'(HL));

        // up+down together: no move
        btn(1'b1, 1'b1, 1'b0);
        frame();
        pix(11'd256, 11'd296);
        chk("updown_hold_box1", 32'(vout.rgb), 32'(HL));

        // enter+down: confirm with idx 1
        btn(1'b0, 1'b1, 1'b1);
        btn(1'b0, 1'b1, 1'b0);
        frame();
        pix(11'd256, 11'd296);
        chk("confirm_f1_box1", 32'(vout.rgb), 32'(HL));
        for (int f = 2; f < 32; f++) begin
            frame();
            pix(11'd256, 11'd296);
            chk($sformatf("blink_f%0d", f), 32'(vout.rgb),
                ((f / 4) % 2 == 1) ? 32'(BG) : 32'(HL));
        end
        chk("no_early_valid", 32'(sv_cnt), 32'd0);
        frame();
        chk("sel_valid_pulse", 32'(sel_valid), 32'd1);
        chk("sel_idx_commit", 32'(sel_idx), 32'd1);
        pix(11'd256, 11'd296);
        chk("sel_valid_one_cycle", 32'(sel_valid), 32'd0);
        chk("done_hl_visible", 32'(vout.rgb), 32'(HL));

        // DONE: buttons ignored
        btn(1'b1, 1'b0, 1'b0);
        btn(1'b0, 1'b0, 1'b1);
        for (int f = 0; f < 6; f++) frame();
        pix(11'd256, 11'd296);
        chk("done_hl_stays", 32'(vout.rgb), 32'(HL));
        chk("done_sel_idx", 32'(sel_idx), 32'd1);
        chk("done_one_pulse", 32'(sv_cnt), 32'd1);

        // menu_active low: back to BROWSE, pass-through, buttons ignored
        menu_active = 1'b0;
        pix(11'd256, 11'd296);
        chk("inactive_passthru", 32'(vout.rgb), 32'(BG));
        btn(1'b0, 1'b1, 1'b0);
        frame();
        menu_active = 1'b1;
        frame();
        pix(11'd256, 11'd296);
        chk("reactive_box1", 32'(vout.rgb), 32'(HL));

        // confirm, then drop menu_active at frame 10
        btn(1'b0, 1'b0, 1'b1);
        for (int f = 0; f < 10; f++) frame();
        menu_active = 1'b0;
        pix(11'd256, 11'd296);
        chk("drop_no_overlay", 32'(vout.rgb), 32'(BG));
        for (int f = 0; f < 3; f++) frame();
        menu_active = 1'b1;
        for (int f = 1; f < 40; f++) begin
            frame();
            if (f == 5) begin
                pix(11'd256, 11'd296);
                chk("drop_browse_no_blink", 32'(vout.rgb), 32'(HL));
            end
        end
        chk("drop_no_valid", 32'(sv_cnt), 32'd1);
        chk("drop_sel_idx_kept", 32'(sel_idx), 32'd1);

        // reset mid-frame during CONFIRM
        btn(1'b0, 1'b0, 1'b1);
        for (int f = 0; f < 5; f++) frame();
        pix(11'd256, 11'd296);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_rgb", 32'(vout.rgb), 32'h0);
        chk("midrst_timing", {vout.hcount, vout.vcount, vout.hsync}, 32'h0);
        chk("midrst_sel_idx", 32'(sel_idx), 32'h0);
        chk("midrst_sel_valid", 32'(sel_valid), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        pix(11'd256, 11'd200);
        chk("postrst_no_hl", 32'(vout.rgb), 32'(BG));
        for (int f = 1; f < 40; f++) begin
            frame();
            if (f == 5) begin
                pix(11'd256, 11'd200);
                chk("postrst_browse_box0", 32'(vout.rgb), 32'(HL));
            end
        end
        chk("postrst_no_valid", 32'(sv_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/menu_select.md
MENU_SELECT -- requirements
Module: menu_select

Interface
REQ-001 Parameter N_OPTIONS, default 3, number of menu entries (2..4).
REQ-002 Parameters BOX_X 256 / BOX_Y0 200 / BOX_W 512 / BOX_H 64 / BOX_PITCH 96 / BORDER 4, geometry of entry k box: x in [BOX_X, BOX_X+BOX_W), y in [BOX_Y0+k*BOX_PITCH, +BOX_H).
REQ-003 Parameter HL_COLOR, default 12'hF_F_F, highlight frame colour; parameter CONFIRM_FRAMES, default 32, confirm-flash duration in frames.
REQ-004 clk  in  1  pixel clock; single clock domain.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 in  vga_if.in  -  timing + rgb stream from the menu background stage.
REQ-007 out  vga_if.out  -  timing + rgb stream with highlight overlay.
REQ-008 menu_active  in  1  level; menu screen shown and navigable.
REQ-009 btn_up, btn_down, btn_enter  in  1 each  single-cycle pulses, clk-synchronous.
REQ-010 sel_idx  out  2  committed selection index.
REQ-011 sel_valid  out  1  one-cycle pulse when selection confirmed.

Function
REQ-012 All out timing fields (vcount, vsync, vblnk, hcount, hsync, hblnk) SHALL equal in fields delayed by exactly 1 clk; out.rgb SHALL be registered with the same 1-clk latency.
REQ-013 frame_start SHALL be true when in.vcount==0 and in.hcount==0.
REQ-014 FSM states BROWSE, CONFIRM, DONE.
REQ-015 BROWSE: btn_up decrements cur_idx, wrapping 0 -> N_OPTIONS-1; btn_down increments, wrapping N_OPTIONS-1 -> 0.
REQ-016 BROWSE: btn_up and btn_down in same cycle -> cur_idx unchanged.
REQ-017 BROWSE: btn_enter -> CONFIRM next cycle, frame counter cleared, cur_idx frozen; simultaneous up/down ignored, enter wins.
REQ-018 CONFIRM: all buttons ignored; frame counter increments on each frame_start; on reaching CONFIRM_FRAMES -> DONE, sel_idx <= cur_idx, sel_valid=1 for exactly that cycle.
REQ-019 DONE: buttons ignored, sel_idx held, no further sel_valid.
REQ-020 menu_active=0 in any state -> BROWSE next cycle, frame counter cleared, cur_idx and sel_idx retained, buttons ignored while low, no sel_valid.
REQ-021 disp_idx SHALL load cur_idx only on frame_start, so a highlight never moves mid-frame.
REQ-022 Highlight visible: BROWSE always; CONFIRM when frame counter bit 2 == 0 (4 frames on, 4 off); DONE always.
REQ-023 Pixel is highlight when menu_active, not in.vblnk/in.hblnk, highlight visible, and pixel lies inside box disp_idx but not inside it inset by BORDER on all sides.
REQ-024 Highlight pixel -> out.rgb = HL_COLOR; otherwise out.rgb = in.rgb unmodified (blanking rgb passes through).
REQ-025 Box y arithmetic SHALL use 11-bit unsigned; no overlay for entries >= N_OPTIONS.

Reset
REQ-026 rst low SHALL asynchronously clear all out fields, sel_idx, sel_valid, cur_idx, disp_idx, frame counter to 0 and state to BROWSE.
REQ-027 Reset asserted mid-CONFIRM SHALL abort confirmation with no sel_valid pulse.
REQ-028 After rst release first highlight appears no earlier than the first frame_start (disp_idx 0).

Verification
REQ-029 Idle stream, menu_active=1, no buttons -> out equals in delayed 1 clk except border ring of box 0 (x 256..259, y 200..263 etc.) = 12'hFFF.
REQ-030 cur_idx=0, btn_up pulse -> cur_idx=2; highlight moves to box 2 (y 392..455) only from next frame_start.
REQ-031 btn_up+btn_down same cycle at idx 1 -> idx stays 1; btn_enter+btn_down same cycle -> CONFIRM with idx 1.
REQ-032 enter at idx 1 -> highlight blinks 4-on/4-off; after 32 frame_starts sel_valid pulses 1 cycle, sel_idx=1, later buttons ignored.
REQ-033 menu_active dropped at frame 10 of CONFIRM -> BROWSE, no sel_valid, no overlay while low, in.rgb passes through.
REQ-034 rst pulsed low mid-frame during CONFIRM -> all outputs 0 immediately, state BROWSE, no sel_valid.
